// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencing,
// with a bounded data-memory wait, illegal-opcode and interrupt traps.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter bit IRQ_EN      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  input  logic       br_taken,
  input  logic       irq,
  output logic       imem_req,
  output logic       ir_en,
  output logic       pc_en,
  output logic       rf_en,
  output logic       rd_en,
  output logic       wr_en,
  output logic       br_take,
  output logic       csr_rd,
  output logic       csr_wr,
  output logic       is_mret,
  output logic       trap,
  output logic [1:0] wb_sel,
  output logic [2:0] mem_acc_mode,
  output logic [1:0] trap_cause,
  output logic [2:0] state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  logic [2:0] state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic [7:0] wait_cnt;
  logic       run;
  logic       is_ld, is_st, is_br, is_jmp, is_sys;
  logic       legal, irq_take, timeout;
  logic [2:0] mode_map;

  assign is_ld    = (opcode == OP_LD);
  assign is_st    = (opcode == OP_ST);
  assign is_br    = (opcode == OP_BR);
  assign is_jmp   = (opcode == OP_JAL) || (opcode == OP_JALR);
  assign is_sys   = (opcode == OP_SYS);
  assign irq_take = IRQ_EN && irq;
  assign timeout  = (wait_cnt == 8'(MEM_TIMEOUT));

  always_comb begin
    mode_map = 3'b111;
    case (funct3)
      3'b000:  mode_map = 3'b000;
      3'b001:  mode_map = 3'b001;
      3'b010:  mode_map = 3'b010;
      3'b100:  mode_map = 3'b011;
      3'b101:  mode_map = 3'b100;
      default: mode_map = 3'b111;
    endcase
  end

  // Loads/stores with a funct3 that has no access mode are rejected at decode.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_BR, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_SYS: legal = 1'b1;
      OP_LD, OP_ST: legal = (mode_map != 3'b111);
      default:      legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH:  if (run && imem_ack) state_d = S_DECODE;
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end
      end
      S_EXEC: begin
        if (is_ld || is_st) begin
          state_d = S_MEM;
        end else if (is_br) begin
          state_d = irq_take ? S_TRAP : S_FETCH;
          if (irq_take) cause_d = 2'b11;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (is_ld) begin
            state_d = S_WB;
          end else begin
            state_d = irq_take ? S_TRAP : S_FETCH;
            if (irq_take) cause_d = 2'b11;
          end
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_WB: begin
        state_d = irq_take ? S_TRAP : S_FETCH;
        if (irq_take) cause_d = 2'b11;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // run keeps imem_req low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      cause_q  <= 2'b00;
      wait_cnt <= 8'd0;
      run      <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      run     <= 1'b1;
      if (state_q != S_MEM)
        wait_cnt <= 8'd0;
      else if (!dmem_ack)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    imem_req     = 1'b0;
    ir_en        = 1'b0;
    pc_en        = 1'b0;
    rf_en        = 1'b0;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    br_take      = 1'b0;
    csr_rd       = 1'b0;
    csr_wr       = 1'b0;
    is_mret      = 1'b0;
    trap         = 1'b0;
    wb_sel       = 2'b01;
    mem_acc_mode = 3'b111;
    case (state_q)
      S_FETCH: begin
        imem_req = run;
        ir_en    = run && imem_ack;
      end
      S_EXEC: begin
        br_take = is_br ? br_taken : is_jmp;
        pc_en   = is_br;
      end
      S_MEM: begin
        rd_en        = is_ld;
        wr_en        = is_st;
        mem_acc_mode = mode_map;
        pc_en        = is_st && dmem_ack;
      end
      S_WB: begin
        pc_en = 1'b1;
        if (is_sys) begin
          wb_sel = 2'b11;
          if (funct3 == 3'b000) begin
            is_mret = 1'b1;
          end else begin
            rf_en  = 1'b1;
            csr_rd = 1'b1;
            csr_wr = 1'b1;
          end
        end else begin
          rf_en = 1'b1;
          if (is_ld)       wb_sel = 2'b10;
          else if (is_jmp) wb_sel = 2'b00;
          else             wb_sel = 2'b01;
        end
      end
      S_TRAP: begin
        trap  = 1'b1;
        pc_en = 1'b1;
      end
      default: ;
    endcase
  end

  assign trap_cause = cause_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: dut_a uses MEM_TIMEOUT=4 with interrupts on, dut_b keeps
// the default timeout with interrupts off; both share stimulus.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       imem_ack, dmem_ack, br_taken, irq;

  logic       imem_req, ir_en, pc_en, rf_en, rd_en, wr_en, br_take;
  logic       csr_rd, csr_wr, is_mret, trap;
  logic [1:0] wb_sel, trap_cause;
  logic [2:0] mem_acc_mode, state;

  logic       imem_req_b, ir_en_b, pc_en_b, rf_en_b, rd_en_b, wr_en_b, br_take_b;
  logic       csr_rd_b, csr_wr_b, is_mret_b, trap_b;
  logic [1:0] wb_sel_b, trap_cause_b;
  logic [2:0] mem_acc_mode_b, state_b;

  int checks   = 0;
  int failures = 0;
  int cnt;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(4), .IRQ_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .br_taken(br_taken), .irq(irq),
    .imem_req(imem_req), .ir_en(ir_en), .pc_en(pc_en), .rf_en(rf_en),
    .rd_en(rd_en), .wr_en(wr_en), .br_take(br_take), .csr_rd(csr_rd),
    .csr_wr(csr_wr), .is_mret(is_mret), .trap(trap), .wb_sel(wb_sel),
    .mem_acc_mode(mem_acc_mode), .trap_cause(trap_cause), .state(state)
  );

  multicycle_controller #(.MEM_TIMEOUT(15), .IRQ_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .br_taken(br_taken), .irq(irq),
    .imem_req(imem_req_b), .ir_en(ir_en_b), .pc_en(pc_en_b), .rf_en(rf_en_b),
    .rd_en(rd_en_b), .wr_en(wr_en_b), .br_take(br_take_b), .csr_rd(csr_rd_b),
    .csr_wr(csr_wr_b), .is_mret(is_mret_b), .trap(trap_b), .wb_sel(wb_sel_b),
    .mem_acc_mode(mem_acc_mode_b), .trap_cause(trap_cause_b), .state(state_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; opcode = '0; funct3 = '0;
    imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0; irq = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  int add_st[7]  = '{0, 0, 0, 1, 2, 4, 0};
  int lw_st[9]   = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
  int sw_st[10]  = '{0, 1, 2, 3, 3, 3, 3, 3, 5, 0};
  int ill_st[4]  = '{0, 1, 5, 0};
  int csr_st[6]  = '{0, 1, 2, 4, 5, 0};
  int seq5_st[5] = '{0, 1, 2, 4, 0};
  int beq_st[5]  = '{0, 1, 2, 5, 0};

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; opcode = '0; funct3 = '0;
    imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0; irq = 1'b0;
    #2;
    check("rst_state", 32'(state), 0);
    check("rst_imem_req", 32'(imem_req), 0);
    check("rst_trap_cause", 32'(trap_cause), 0);
    check("rst_pc_en", 32'(pc_en), 0);
    check("rst_mem_acc_mode", 32'(mem_acc_mode), 7);
    tick;
    rst_n = 1'b1;
    #1;
    check("imem_req_before_edge", 32'(imem_req), 0);
    tick;
    check("imem_req_after_edge", 32'(imem_req), 1);

    // ADD, instruction arrives on the third fetch cycle
    opcode = 7'b0110011;
    for (int i = 0; i < 7; i++) begin
      imem_ack = (i == 2); #1;
      check("add_state", 32'(state), 32'(add_st[i]));
      check("add_rf_en", 32'(rf_en), 32'(i == 5));
      check("add_ir_en", 32'(ir_en), 32'(i == 2));
      if (i == 5) check("add_wb_sel", 32'(wb_sel), 1);
      tick;
    end

    // LW, data arrives on the fourth MEM cycle
    opcode = 7'b0000011; funct3 = 3'b010; cnt = 0;
    for (int i = 0; i < 9; i++) begin
      imem_ack = (i == 0); dmem_ack = (i == 6); #1;
      check("lw_state", 32'(state), 32'(lw_st[i]));
      check("lw_rd_en", 32'(rd_en), 32'(lw_st[i] == 3));
      if (lw_st[i] == 3) check("lw_mode", 32'(mem_acc_mode), 2);
      if (i == 7) begin
        check("lw_wb_sel", 32'(wb_sel), 2);
        check("lw_rf_en", 32'(rf_en), 1);
      end
      cnt += int'(rd_en);
      tick;
    end
    check("lw_rd_cycles", 32'(cnt), 4);
    dmem_ack = 1'b0;

    do_reset;
    // illegal opcode
    opcode = 7'b1111111;
    for (int i = 0; i < 4; i++) begin
      imem_ack = (i == 0); #1;
      check("ill_state", 32'(state), 32'(ill_st[i]));
      check("ill_rf_en", 32'(rf_en), 0);
      check("ill_trap", 32'(trap), 32'(i == 2));
      if (i == 2) check("ill_cause", 32'(trap_cause), 1);
      tick;
    end

    // CSRRW with irq during WB: completes WB, then traps (dut_b ignores irq)
    opcode = 7'b1110011; funct3 = 3'b001;
    for (int i = 0; i < 6; i++) begin
      imem_ack = (i == 0); irq = (i == 3); #1;
      check("csr_state", 32'(state), 32'(csr_st[i]));
      if (i == 3) begin
        check("csr_rd", 32'(csr_rd), 1);
        check("csr_wr", 32'(csr_wr), 1);
        check("csr_rf_en", 32'(rf_en), 1);
        check("csr_wb_sel", 32'(wb_sel), 3);
      end
      if (i == 4) begin
        check("csr_irq_cause", 32'(trap_cause), 3);
        check("csr_noirq_state_b", 32'(state_b), 0);
      end
      tick;
    end
    irq = 1'b0;

    // JAL
    opcode = 7'b1101111; funct3 = 3'b000;
    for (int i = 0; i < 5; i++) begin
      imem_ack = (i == 0); #1;
      check("jal_state", 32'(state), 32'(seq5_st[i]));
      if (i == 2) check("jal_br_take", 32'(br_take), 1);
      if (i == 3) check("jal_wb_sel", 32'(wb_sel), 0);
      tick;
    end

    // MRET
    opcode = 7'b1110011; funct3 = 3'b000;
    for (int i = 0; i < 5; i++) begin
      imem_ack = (i == 0); #1;
      check("mret_state", 32'(state), 32'(seq5_st[i]));
      if (i == 3) begin
        check("mret_is_mret", 32'(is_mret), 1);
        check("mret_rf_en", 32'(rf_en), 0);
        check("mret_pc_en", 32'(pc_en), 1);
        check("mret_csr_wr", 32'(csr_wr), 0);
      end
      tick;
    end

    // SW with no ack: timeout after MEM_TIMEOUT+1 cycles
    opcode = 7'b0100011; funct3 = 3'b010; cnt = 0;
    for (int i = 0; i < 10; i++) begin
      imem_ack = (i == 0); #1;
      check("sw_state", 32'(state), 32'(sw_st[i]));
      check("sw_trap", 32'(trap), 32'(i == 8));
      if (i == 8) begin
        check("sw_cause", 32'(trap_cause), 2);
        check("sw_trap_pc_en", 32'(pc_en), 1);
      end
      if (i == 9) check("sw_cause_hold", 32'(trap_cause), 2);
      cnt += int'(wr_en);
      tick;
    end
    check("sw_wr_cycles", 32'(cnt), 5);

    do_reset;
    // BEQ taken, irq rises in EXEC
    opcode = 7'b1100011; funct3 = 3'b000; br_taken = 1'b1;
    for (int i = 0; i < 5; i++) begin
      imem_ack = (i == 0); irq = (i >= 2); #1;
      check("beq_state", 32'(state), 32'(beq_st[i]));
      if (i == 2) begin
        check("beq_br_take", 32'(br_take), 1);
        check("beq_pc_en", 32'(pc_en), 1);
      end
      if (i == 3) begin
        check("beq_irq_cause", 32'(trap_cause), 3);
        check("beq_noirq_state_b", 32'(state_b), 0);
        check("beq_noirq_trap_b", 32'(trap_b), 0);
      end
      tick;
    end
    irq = 1'b0; br_taken = 1'b0;

    // reset pulsed in the middle of a load
    opcode = 7'b0000011; funct3 = 3'b001;
    for (int i = 0; i < 4; i++) begin
      imem_ack = (i == 0); #1;
      tick;
    end
    check("mid_state", 32'(state), 3);
    check("mid_rd_en", 32'(rd_en), 1);
    check("mid_mode", 32'(mem_acc_mode), 1);
    rst_n = 1'b0; #1;
    check("mid_rst_rd_en", 32'(rd_en), 0);
    check("mid_rst_state", 32'(state), 0);
    check("mid_rst_mode", 32'(mem_acc_mode), 7);
    check("mid_rst_imem_req", 32'(imem_req), 0);
    tick;
    rst_n = 1'b1;
    tick;
    check("resume_imem_req", 32'(imem_req), 1);
    imem_ack = 1'b1; #1;
    check("resume_ir_en", 32'(ir_en), 1);
    tick;
    imem_ack = 1'b0;
    check("resume_decode", 32'(state), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
